// File: rtl/pipe_skid_reg_pkg.sv
// Shared CPU pipeline definitions: stage-state encoding and exception vector layout.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } PipeStageState;

    typedef struct packed {
        logic instr_misalign;
        logic instr_fault;
        logic illegal_instr;
        logic breakpoint;
        logic load_misalign;
        logic load_fault;
        logic store_misalign;
        logic store_fault;
        logic ecall;
    } ExceptinPipeType;

    // The state encoding doubles as the held-entry count.
    function automatic logic [1:0] state_occ(input PipeStageState s);
        return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
    endfunction

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// One pipeline register slot: payload plus exception vector, with load enable and clear.
module pipe_reg_slot #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 9
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [EXC_W-1:0]  exc_i,
    output logic [DATA_W-1:0] data_o,
    output logic [EXC_W-1:0]  exc_o
);

    logic [DATA_W-1:0] data_q;
    logic [EXC_W-1:0]  exc_q;

    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            data_q <= '0;
            exc_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            exc_q  <= exc_i;
        end
    end

    assign data_o = data_q;
    assign exc_o  = exc_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline stage with registered in_ready and a saturating stall counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXC_W  = $bits(ExceptinPipeType),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    PipeStageState     state_q, state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [1:0]        occ_q;
    logic [CNT_W-1:0]  stall_q;

    logic              in_fire, out_fire;
    logic              main_load, main_from_skid, skid_load;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;
    logic [EXC_W-1:0]  main_exc, skid_exc, main_exc_d;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_data_d = main_from_skid ? skid_data : in_data;
    assign main_exc_d  = main_from_skid ? skid_exc  : in_exc;

    // Handshake outputs are registered from the next state, so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= state_occ(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    pipe_reg_slot #(
        .DATA_W(DATA_W),
        .EXC_W (EXC_W)
    ) u_main (
        .clk   (clk),
        .rst_i (rst),
        .clr_i (flush),
        .load_i(main_load),
        .data_i(main_data_d),
        .exc_i (main_exc_d),
        .data_o(main_data),
        .exc_o (main_exc)
    );

    pipe_reg_slot #(
        .DATA_W(DATA_W),
        .EXC_W (EXC_W)
    ) u_skid (
        .clk   (clk),
        .rst_i (rst),
        .clr_i (flush),
        .load_i(skid_load),
        .data_i(in_data),
        .exc_i (in_exc),
        .data_o(skid_data),
        .exc_o (skid_exc)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign out_exc   = main_exc;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: FIFO model of held entries, stall counter model, directed and random traffic.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int EXC_W  = 9;
    localparam int CNT_W  = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [EXC_W-1:0]  in_exc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [EXC_W-1:0]  out_exc;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_skid_reg #(
        .DATA_W(DATA_W),
        .EXC_W (EXC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_exc   (in_exc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exc  (out_exc),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [EXC_W+DATA_W-1:0] sb_q[$];
    logic [EXC_W+DATA_W-1:0] last_main = '0;
    int unsigned             stall_exp = 0;
    bit                      primed = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare pre-edge outputs with the model, then advance the model.
    task automatic step(input logic r, input logic fl, input logic iv,
                        input logic [DATA_W-1:0] d, input logic [EXC_W-1:0] e,
                        input logic ordy);
        bit in_f, out_f;
        @(negedge clk);
        rst = r; flush = fl; in_valid = iv; in_data = d; in_exc = e; out_ready = ordy;
        #1;
        in_f  = iv && (sb_q.size() < 2);
        out_f = (sb_q.size() > 0) && ordy;
        if (primed) begin
            chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
            chk("in_ready",  64'(in_ready),  64'(sb_q.size() != 2));
            chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
            if (sb_q.size() == 0)
                chk("idle_hold", 64'({out_exc, out_data}), 64'(last_main));
            else if (!out_f)
                chk("stall_hold", 64'({out_exc, out_data}), 64'(sb_q[0]));
        end
        if (r) begin
            sb_q.delete();
            stall_exp = 0;
            last_main = '0;
            primed = 1'b1;
        end else if (primed) begin
            if ((sb_q.size() > 0) && !ordy && (stall_exp != STALL_MAX)) stall_exp++;
            if (out_f) begin
                chk("sb_pop", 64'({out_exc, out_data}), 64'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (fl) begin
                sb_q.delete();
                last_main = '0;
            end else if (in_f) begin
                sb_q.push_back({e, d});
            end
            if (sb_q.size() > 0) last_main = sb_q[0];
        end
        @(posedge clk);
    endtask

    initial begin
        step(1, 0, 0, '0, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_exc", 64'(out_exc), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Single entry, one-cycle latency
        step(0, 0, 1, 32'hA5, '0, 1);
        #2;
        chk("a5_valid", 64'(out_valid), 64'd1);
        chk("a5_data", 64'(out_data), 64'hA5);
        chk("a5_occ", 64'(occupancy), 64'd1);
        step(0, 0, 0, '0, '0, 1);

        // Back-pressure fills main then skid; third entry refused
        step(0, 0, 1, 32'h1, '0, 0);
        #2 chk("fill1_occ", 64'(occupancy), 64'd1);
        step(0, 0, 1, 32'h2, '0, 0);
        #2 chk("fill2_occ", 64'(occupancy), 64'd2);
        chk("fill2_in_ready", 64'(in_ready), 64'd0);
        step(0, 0, 1, 32'h3, '0, 0);
        #2 chk("fill3_data", 64'(out_data), 64'h1);
        chk("fill3_occ", 64'(occupancy), 64'd2);

        // Drain FULL in order
        step(0, 0, 0, '0, '0, 1);
        #2 chk("drain_in_ready", 64'(in_ready), 64'd1);
        chk("drain_data", 64'(out_data), 64'h2);
        step(0, 0, 0, '0, '0, 1);
        #2 chk("drain_occ", 64'(occupancy), 64'd0);

        // Flush in FULL drops the concurrent input
        step(0, 0, 1, 32'h5, '0, 0);
        step(0, 0, 1, 32'h6, '0, 0);
        step(0, 1, 1, 32'h9, '0, 0);
        #2 chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        repeat (3) step(0, 0, 0, '0, '0, 1);

        // Stall counter saturation, then reset clears it
        step(0, 0, 1, 32'h44, '0, 0);
        repeat (20) step(0, 0, 0, '0, '0, 0);
        #2 chk("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
        step(1, 0, 0, '0, '0, 0);
        #2 chk("stall_rst", 64'(stall_cnt), 64'd0);

        // Reset while FULL
        step(0, 0, 1, 32'h11, '0, 0);
        step(0, 0, 1, 32'h12, '0, 0);
        step(1, 1, 1, 32'h13, '0, 1);
        #2 chk("rstfull_occ", 64'(occupancy), 64'd0);
        chk("rstfull_data", 64'(out_data), 64'd0);

        // Exception travels with its payload and holds through a stall
        step(0, 0, 1, 32'h7, 9'h100, 0);
        #2 chk("exc_data", 64'(out_data), 64'h7);
        chk("exc_vec", 64'(out_exc), 64'h100);
        repeat (3) step(0, 0, 0, '0, '0, 0);
        #2 chk("exc_hold", 64'(out_exc), 64'h100);
        step(0, 0, 0, '0, '0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), $urandom, EXC_W'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (4) step(0, 0, 0, '0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter EXC_W, default 9: exception-vector width; 9 is the width of ExceptinPipeType.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 flush  input  1: drop all held entries.
REQ-007 in_valid  input  1: upstream offers an entry.
REQ-008 in_ready  output  1: stage accepts an entry this cycle.
REQ-009 in_data  input  DATA_W: upstream payload.
REQ-010 in_exc  input  EXC_W: upstream exception vector.
REQ-011 out_valid  output  1: stage presents an entry.
REQ-012 out_ready  input  1: downstream accepts the entry.
REQ-013 out_data  output  DATA_W: presented payload.
REQ-014 out_exc  output  EXC_W: presented exception vector.
REQ-015 occupancy  output  2: number of held entries, 0..2.
REQ-016 stall_cnt  output  CNT_W: saturating count of back-pressure cycles.

Function
REQ-017 Define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 The stage SHALL hold a main slot and a skid slot, controlled by three states: EMPTY (occ 0), BUSY (occ 1), FULL (occ 2).
REQ-019 in_ready SHALL be 1 exactly when the state is not FULL, and SHALL be a registered signal with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data and out_exc SHALL always come from the main slot.
REQ-021 EMPTY + in_fire: main <= in; next state BUSY. Latency from in to out SHALL be 1 cycle.
REQ-022 BUSY + in_fire + out_fire: main <= in; state stays BUSY.
REQ-023 BUSY + in_fire only: skid <= in; next state FULL.
REQ-024 BUSY + out_fire only: next state EMPTY.
REQ-025 FULL + out_fire: main <= skid; next state BUSY. in_valid is ignored in FULL.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_exc SHALL stay stable.
REQ-027 flush SHALL take priority over every other event: next state EMPTY, both slots zeroed, and any in_valid in the same cycle dropped.
REQ-028 stall_cnt SHALL increment each cycle out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and ignore flush.
REQ-029 In EMPTY, out_data and out_exc SHALL keep their last value; they are zero only after reset or flush.
REQ-030 Data ordering SHALL be strictly FIFO; no entry is lost or duplicated except by flush.

Reset
REQ-031 With rst=1 at a clock edge, the next cycle SHALL show: state EMPTY, in_ready=1, out_valid=0, out_data=0, out_exc=0, occupancy=0, stall_cnt=0.
REQ-032 rst SHALL dominate flush and all handshakes, including when asserted mid-transfer in FULL.

Structure
REQ-033 The state enum PipeStageState (EMPTY/BUSY/FULL) and ExceptinPipeType SHALL reside in the shared CPU defines package; EXC_W defaults to $bits(ExceptinPipeType).
REQ-034 One sub-module, pipe_reg_slot (payload and exception register with load enable and clear), SHALL be instantiated twice, as main and skid.
REQ-035 No other logic SHALL be split into sub-modules.

Verification
REQ-036 Reset, then in_valid=1 with data 0xA5 and out_ready=1 -> out_valid=1 and out_data=0xA5 one cycle later; occupancy=1.
REQ-037 Stream 0x1,0x2,0x3 with out_ready=0 -> occupancy 1 then 2; in_ready=0 after the 2nd accept; 0x3 held off; out_data stays 0x1.
REQ-038 From FULL (0x1,0x2), raise out_ready for 2 cycles -> out sequence 0x1 then 0x2; in_ready returns to 1 one cycle after the first out_fire.
REQ-039 In FULL, assert flush together with in_valid (0x9) -> next cycle: EMPTY, out_valid=0, out_data=0; 0x9 never appears at the output.
REQ-040 With CNT_W=4 and out_valid=1, hold out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); then rst -> stall_cnt=0.
REQ-041 Set in_exc=9'h100 with data 0x7 -> out_exc=9'h100 in the same cycle as out_data=0x7, unchanged through a 3-cycle stall.
